// File: rtl/uart_input_handler.sv
// UART command-frame receiver: 'L' + 24 hex chars + CR/LF becomes command/address/data
// words, which are offered to the wishbone master with a valid/ready handshake.
module uart_input_handler #(
  parameter logic [7:0] START_CHAR     = 8'h4C,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TIMEOUT_WIDTH  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uart_byte,
  input  logic        byte_en,
  output logic [31:0] command,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic        command_valid,
  input  logic        master_ready,
  output logic        frame_error,
  output logic        overrun,
  output logic        busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] READ_CMD  = 3'd1;
  localparam logic [2:0] READ_ADDR = 3'd2;
  localparam logic [2:0] READ_DATA = 3'd3;
  localparam logic [2:0] WAIT_EOL  = 3'd4;
  localparam logic [2:0] HOLD      = 3'd5;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [2:0]               state;
  logic [2:0]               nib_cnt;
  logic [TIMEOUT_WIDTH-1:0] timer;
  logic                     hex_ok;
  logic [3:0]               hex_val;
  logic                     is_start;
  logic                     is_eol;
  logic                     in_frame;
  logic                     timed_out;

  // NOTE: every variable gets a default before the if-chain, so no path leaves one unassigned (no latch).
  always_comb begin
    hex_ok  = 1'b1;
    hex_val = 4'h0;
    if (uart_byte >= 8'h30 && uart_byte <= 8'h39)
      hex_val = uart_byte[3:0];
    else if (uart_byte >= 8'h61 && uart_byte <= 8'h66)
      hex_val = 4'(uart_byte - 8'h57);
    else if (uart_byte >= 8'h41 && uart_byte <= 8'h46)
      hex_val = 4'(uart_byte - 8'h37);
    else
      hex_ok = 1'b0;
  end

  assign is_start  = (uart_byte == START_CHAR);
  assign is_eol    = (uart_byte == 8'h0D) || (uart_byte == 8'h0A);
  assign in_frame  = (state == READ_CMD) || (state == READ_ADDR) ||
                     (state == READ_DATA) || (state == WAIT_EOL);
  assign timed_out = !byte_en && (timer == TIMEOUT_LAST);
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      nib_cnt       <= 3'd0;
      timer         <= '0;
      command       <= 32'h0;
      address       <= 32'h0;
      data          <= 32'h0;
      command_valid <= 1'b0;
      frame_error   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;

      if (in_frame && !byte_en)
        timer <= timer + 1'b1;
      else
        timer <= '0;

      case (state)
        IDLE: begin
          if (byte_en && is_start) begin
            state   <= READ_CMD;
            nib_cnt <= 3'd0;
          end
        end

        READ_CMD, READ_ADDR, READ_DATA: begin
          if (byte_en) begin
            if (hex_ok) begin
              case (state)
                READ_CMD:  command <= {command[27:0], hex_val};
                READ_ADDR: address <= {address[27:0], hex_val};
                default:   data    <= {data[27:0], hex_val};
              endcase
              // nib_cnt wraps to 0 on the 8th nibble, ready for the next word
              nib_cnt <= nib_cnt + 3'd1;
              if (nib_cnt == 3'd7) begin
                case (state)
                  READ_CMD:  state <= READ_ADDR;
                  READ_ADDR: state <= READ_DATA;
                  default:   state <= WAIT_EOL;
                endcase
              end
            end else if (is_start) begin
              state   <= READ_CMD;
              nib_cnt <= 3'd0;
            end else begin
              frame_error <= 1'b1;
              state       <= IDLE;
            end
          end else if (timed_out) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end
        end

        WAIT_EOL: begin
          if (byte_en) begin
            if (is_eol) begin
              state         <= HOLD;
              command_valid <= 1'b1;
            end else if (is_start) begin
              state   <= READ_CMD;
              nib_cnt <= 3'd0;
            end else begin
              frame_error <= 1'b1;
              state       <= IDLE;
            end
          end else if (timed_out) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end
        end

        HOLD: begin
          // The UART is never stalled: anything arriving now is dropped and flagged.
          overrun <= byte_en;
          if (master_ready) begin
            command_valid <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          command_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_input_handler.sv
// Self-checking bench for uart_input_handler: directed frame table, handshake/timeout/reset
// sequences, and random frames checked against a string-level frame model.
module tb_uart_input_handler;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  uart_byte;
  logic        byte_en;
  logic        master_ready;
  logic [31:0] command;
  logic [31:0] address;
  logic [31:0] data;
  logic        command_valid;
  logic        frame_error;
  logic        overrun;
  logic        busy;

  always #5 clk = ~clk;

  uart_input_handler #(
    .START_CHAR    (8'h4C),
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_WIDTH (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_byte    (uart_byte),
    .byte_en      (byte_en),
    .command      (command),
    .address      (address),
    .data         (data),
    .command_valid(command_valid),
    .master_ready (master_ready),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  // Event monitor, sampled on the inactive edge
  int          err_cnt = 0;
  int          ovr_cnt = 0;
  int          val_rise = 0;
  int          val_hi = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] cap_cmd = 32'h0;
  logic [31:0] cap_addr = 32'h0;
  logic [31:0] cap_data = 32'h0;

  always @(negedge clk) begin
    prev_valid <= command_valid;
    if (frame_error) err_cnt <= err_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (command_valid) val_hi <= val_hi + 1;
    if (command_valid && !prev_valid) begin
      val_rise <= val_rise + 1;
      cap_cmd  <= command;
      cap_addr <= address;
      cap_data <= data;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    uart_byte = b;
    byte_en   = 1'b1;
    @(negedge clk);
    byte_en   = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] v, input bit lower);
    if (v < 4'd10) return 8'h30 + 8'(v);
    return (lower ? 8'h61 : 8'h41) + 8'(v) - 8'd10;
  endfunction

  typedef struct {
    string       s;
    logic [31:0] cmd;
    logic [31:0] addr;
    logic [31:0] dat;
    int          n_valid;
    int          n_err;
  } vec_t;

  vec_t        vecs[6];
  string       badset = "GzZq!#@ -";
  int          e0, v0, o0, h0;
  int          bad_pos;
  logic        early;
  logic [3:0]  nib[24];
  logic [31:0] w[3];
  logic [7:0]  c;

  initial begin
    vecs[0] = '{"L89ABCDEFFEDCBA9801234567\n", 32'h89ABCDEF, 32'hFEDCBA98, 32'h01234567, 1, 0};
    vecs[1] = '{"  x#Lfedcba9876543210abcdef01\015", 32'hFEDCBA98, 32'h76543210, 32'hABCDEF01, 1, 0};
    vecs[2] = '{"L1234G", 32'h0, 32'h0, 32'h0, 0, 1};
    vecs[3] = '{"L1234L0000000100000002000000FF\n", 32'h00000001, 32'h00000002, 32'h000000FF, 1, 0};
    vecs[4] = '{"L0123456789ABCDEF01234567Z", 32'h0, 32'h0, 32'h0, 0, 1};
    vecs[5] = '{"LdeadBEEFcafeF00D12345678\n", 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 1, 0};

    rst = 1'b1; byte_en = 1'b0; uart_byte = 8'h00; master_ready = 1'b0;
    idle(3);
    check("reset outputs", {command, address, data, command_valid, frame_error, overrun, busy}, 0);
    rst = 1'b0;
    idle(2);

    // Directed frame table, master always ready
    master_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e0 = err_cnt; v0 = val_rise;
      send_str(vecs[i].s);
      idle(3);
      check($sformatf("vec%0d frame_error count", i), err_cnt - e0, vecs[i].n_err);
      check($sformatf("vec%0d valid count", i), val_rise - v0, vecs[i].n_valid);
      if (vecs[i].n_valid > 0)
        check($sformatf("vec%0d words", i), {cap_cmd, cap_addr, cap_data},
              {vecs[i].cmd, vecs[i].addr, vecs[i].dat});
    end

    // Held frame with overruns, then acceptance
    master_ready = 1'b0;
    send_str(vecs[0].s);
    check("valid latency", command_valid, 1'b1);
    o0 = ovr_cnt;
    for (int k = 0; k < 20; k++) begin
      if (k == 3 || k == 9 || k == 15) send_byte(8'h4C);
      else idle(1);
    end
    check("overrun count", ovr_cnt - o0, 3);
    check("valid held", {command_valid, busy}, 2'b11);
    check("words stable in hold", {command, address, data}, {32'h89ABCDEF, 32'hFEDCBA98, 32'h01234567});
    master_ready = 1'b1;
    idle(1);
    master_ready = 1'b0;
    check("valid drop after accept", {command_valid, busy}, 2'b00);
    check("words kept after accept", {command, address, data}, {32'h89ABCDEF, 32'hFEDCBA98, 32'h01234567});

    // Byte coincident with acceptance is dropped, flagged, and does not start a frame
    idle(2);
    send_str(vecs[5].s);
    check("valid before coincident", command_valid, 1'b1);
    master_ready = 1'b1;
    send_byte(8'h4C);
    master_ready = 1'b0;
    check("coincident overrun", {overrun, command_valid, busy}, 3'b100);
    idle(2);

    // Inter-byte timeout after 10 hex chars
    send_str("L0123456789");
    early = 1'b0;
    repeat (15) begin
      idle(1);
      if (frame_error || !busy) early = 1'b1;
    end
    check("no early timeout", early, 1'b0);
    idle(1);
    check("timeout error", {frame_error, busy}, 2'b10);
    idle(1);
    check("timeout pulse width", frame_error, 1'b0);

    // Reset mid-frame and mid-handshake
    send_str("L0123");
    rst = 1'b1;
    idle(1);
    check("reset mid-frame", {command, address, data, command_valid, frame_error, overrun, busy}, 0);
    rst = 1'b0;
    idle(1);
    send_str(vecs[0].s);
    check("valid before reset", command_valid, 1'b1);
    rst = 1'b1;
    idle(1);
    check("reset mid-handshake", {command, address, data, command_valid, frame_error, overrun, busy}, 0);
    rst = 1'b0;
    idle(2);

    // Back-to-back frames with ready tied high
    master_ready = 1'b1;
    v0 = val_rise; h0 = val_hi; o0 = ovr_cnt;
    send_str(vecs[0].s);
    check("b2b frame1", {command_valid, command, address, data},
          {1'b1, 32'h89ABCDEF, 32'hFEDCBA98, 32'h01234567});
    idle(1);
    send_str(vecs[5].s);
    check("b2b frame2", {command_valid, command, address, data},
          {1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678});
    idle(3);
    check("b2b pulses", {val_rise - v0, val_hi - h0, ovr_cnt - o0}, {32'd2, 32'd2, 32'd0});

    // Random frames vs. string-level model
    for (int f = 0; f < 30; f++) begin
      bad_pos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : -1;
      e0 = err_cnt; v0 = val_rise;
      repeat ($urandom_range(0, 3)) send_byte(badset[int'($urandom_range(0, 8))]);
      idle(int'($urandom_range(0, 3)));
      send_byte(8'h4C);
      for (int k = 0; k < 25; k++) begin
        if (k < 24) begin
          nib[k] = 4'($urandom_range(0, 15));
          c = hex_char(nib[k], 1'($urandom_range(0, 1)));
        end else begin
          c = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D;
        end
        if (k == bad_pos) c = badset[int'($urandom_range(0, 8))];
        send_byte(c);
        idle(int'($urandom_range(0, 5)));
      end
      idle(3);
      for (int j = 0; j < 3; j++) begin
        w[j] = 32'h0;
        for (int i = 0; i < 8; i++) w[j] = w[j] * 16 + 32'(nib[j * 8 + i]);
      end
      check($sformatf("rand%0d frame_error count", f), err_cnt - e0, (bad_pos >= 0) ? 1 : 0);
      check($sformatf("rand%0d valid count", f), val_rise - v0, (bad_pos >= 0) ? 0 : 1);
      if (bad_pos < 0)
        check($sformatf("rand%0d words", f), {cap_cmd, cap_addr, cap_data}, {w[0], w[1], w[2]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
